// File: rtl/mem_stage_unit_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : mem_stage_unit_pkg                                           |
// | Purpose  : Shared access-size encodings, lane-enable constants, load    |
// |            kinds and the byte-enable helper used by the memory stage.   |
// | Ports    : none (package)                                               |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

package mem_stage_unit_pkg;

  // Access-size encoding used by the store lane logic.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Byte-lane enables, bit i = byte lane i (little-endian).
  localparam logic [3:0] c_LANE_NONE    = 4'b0000;
  localparam logic [3:0] c_LANE_BYTE0   = 4'b0001;
  localparam logic [3:0] c_LANE_LO_HALF = 4'b0011;
  localparam logic [3:0] c_LANE_HI_HALF = 4'b1100;
  localparam logic [3:0] c_LANE_ALL     = 4'b1111;

  // Load kinds after priority resolution of the M-stage load flags.
  typedef enum logic [2:0] {
    LD_WORD   = 3'd0,
    LD_HALF_S = 3'd1,
    LD_HALF_U = 3'd2,
    LD_BYTE_S = 3'd3,
    LD_BYTE_U = 3'd4
  } loadKind_e;

  // Byte enable for a store of the given size at the given byte offset.
  // Offset bits finer than the access granularity are ignored.
  function automatic logic [3:0] byteEnable(input logic [1:0] size,
                                            input logic [1:0] offset);
    logic [3:0] en;
    en = c_LANE_NONE;
    case (size)
      SIZE_W:  en = c_LANE_ALL;
      SIZE_H:  en = offset[1] ? c_LANE_HI_HALF : c_LANE_LO_HALF;
      SIZE_B:  en = c_LANE_BYTE0 << offset;
      default: en = c_LANE_NONE;
    endcase
    return en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_unit_load_ext.sv
// ---------------------------------------------------------------------------
// | Module   : mem_load_ext                                                 |
// | Purpose  : Combinational byte/half select from a 32-bit memory word     |
// |            followed by sign or zero extension to 32 bits.               |
// | Ports    : rdWord     in  32  word read from data memory                |
// |            byteOffset in  2   address bits [1:0]                        |
// |            loadKind   in  3   resolved load kind (loadKind_e)           |
// |            loadData   out 32  extended load result                      |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module mem_load_ext
  import mem_stage_unit_pkg::*;
(
  input  logic [31:0] rdWord,
  input  logic [1:0]  byteOffset,
  input  loadKind_e   loadKind,
  output logic [31:0] loadData
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Half selected by offset[1], byte by the full offset (little-endian).
  assign w_half = byteOffset[1] ? rdWord[31:16] : rdWord[15:0];
  assign w_byte = rdWord[8*byteOffset +: 8];

  always_comb begin
    loadData = rdWord;
    case (loadKind)
      LD_WORD:   loadData = rdWord;
      LD_HALF_S: loadData = {{16{w_half[15]}}, w_half};
      LD_HALF_U: loadData = {16'h0000, w_half};
      LD_BYTE_S: loadData = {{24{w_byte[7]}}, w_byte};
      LD_BYTE_U: loadData = {24'h000000, w_byte};
      default:   loadData = rdWord;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_unit.sv
// ---------------------------------------------------------------------------
// | Module   : mem_stage_unit                                               |
// | Purpose  : Memory pipeline stage. Byte/half/word stores into an         |
// |            internal data memory, asynchronous read with load            |
// |            extension, and the M/W pipeline register.                    |
// | Ports    : clk, reset (sync, active-high)                               |
// |            M-stage inputs : RegWriteM, MemtoRegM, MemWriteM, WriteRegM, |
// |              ALUresultM, MemWriteDataM, PCplus4M, jalM, jalrM,          |
// |              bgezalrM, swM, shM, sbM, lwM, lhM, lhuM, lbM, lbuM         |
// |            W-stage outputs: RegWriteW, MemtoRegW, WriteRegW,            |
// |              ALUresultW, ReadDataW, PCplus4W, jalW, jalrW, bgezalrW,    |
// |              MemExcW                                                    |
// | Options  : MEM_MISALIGN_TRAP_EN - suppress misaligned stores, flag      |
// |            misaligned accesses on MemExcW and squash their write-back.  |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] ALUresultM,
  input  logic [31:0] MemWriteDataM,
  input  logic [31:0] PCplus4M,
  input  logic        jalM,
  input  logic        jalrM,
  input  logic        bgezalrM,
  input  logic        swM,
  input  logic        shM,
  input  logic        sbM,
  input  logic        lwM,
  input  logic        lhM,
  input  logic        lhuM,
  input  logic        lbM,
  input  logic        lbuM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ALUresultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCplus4W,
  output logic        jalW,
  output logic        jalrW,
  output logic        bgezalrW,
  output logic        MemExcW
);

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] w_wordIdx;
  logic [1:0]        w_offset;
  logic              w_inRange;
  logic [1:0]        w_storeSize;
  logic [3:0]        w_byteEn;
  logic [31:0]       w_storeData;
  logic              w_storeEn;
  logic              w_misaligned;
  logic [31:0]       w_readWord;
  loadKind_e         w_loadKind;
  logic [31:0]       w_loadData;

  assign w_wordIdx = ALUresultM[ADDR_W+1:2];
  assign w_offset  = ALUresultM[1:0];
  assign w_inRange = (ALUresultM[31:ADDR_W+2] == '0);

  // Store width: sw > sh > sb; a bare MemWriteM is a word store.
  always_comb begin
    w_storeSize = SIZE_W;
    if (swM)      w_storeSize = SIZE_W;
    else if (shM) w_storeSize = SIZE_H;
    else if (sbM) w_storeSize = SIZE_B;
  end

  // Load kind: lw > lh > lhu > lb > lbu; no flag reads the full word.
  always_comb begin
    w_loadKind = LD_WORD;
    if (lwM)       w_loadKind = LD_WORD;
    else if (lhM)  w_loadKind = LD_HALF_S;
    else if (lhuM) w_loadKind = LD_HALF_U;
    else if (lbM)  w_loadKind = LD_BYTE_S;
    else if (lbuM) w_loadKind = LD_BYTE_U;
  end

  // Replicate the low data bits across lanes so the byte enable alone
  // decides which lanes change.
  always_comb begin
    w_storeData = MemWriteDataM;
    case (w_storeSize)
      SIZE_H:  w_storeData = {2{MemWriteDataM[15:0]}};
      SIZE_B:  w_storeData = {4{MemWriteDataM[7:0]}};
      default: w_storeData = MemWriteDataM;
    endcase
  end

  assign w_byteEn = byteEnable(w_storeSize, w_offset);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_storeMis;
  logic w_loadMis;

  assign w_storeMis = MemWriteM &&
                      (((w_storeSize == SIZE_W) && (w_offset != 2'b00)) ||
                       ((w_storeSize == SIZE_H) && w_offset[0]));
  assign w_loadMis  = ((w_loadKind == LD_WORD) && lwM && (w_offset != 2'b00)) ||
                      (((w_loadKind == LD_HALF_S) || (w_loadKind == LD_HALF_U)) &&
                       w_offset[0]);
  assign w_misaligned = w_storeMis || w_loadMis;
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_storeEn = MemWriteM && w_inRange && !w_misaligned;

  // Data memory: reset clears every word and drops any concurrent store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_storeEn) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byteEn[b]) begin
          r_mem[w_wordIdx][8*b +: 8] <= w_storeData[8*b +: 8];
        end
      end
    end
  end

  assign w_readWord = w_inRange ? r_mem[w_wordIdx] : 32'h0000_0000;

  mem_load_ext u_loadExt (
    .rdWord     (w_readWord),
    .byteOffset (w_offset),
    .loadKind   (w_loadKind),
    .loadData   (w_loadData)
  );

  // M/W pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      WriteRegW  <= 5'd0;
      ALUresultW <= 32'h0;
      ReadDataW  <= 32'h0;
      PCplus4W   <= 32'h0;
      jalW       <= 1'b0;
      jalrW      <= 1'b0;
      bgezalrW   <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM && !w_misaligned;
      MemtoRegW  <= MemtoRegM;
      WriteRegW  <= WriteRegM;
      ALUresultW <= ALUresultM;
      ReadDataW  <= w_misaligned ? 32'h0 : w_loadData;
      PCplus4W   <= PCplus4M;
      jalW       <= jalM;
      jalrW      <= jalrM;
      bgezalrW   <= bgezalrM;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_memExc;

  always_ff @(posedge clk) begin
    if (reset) r_memExc <= 1'b0;
    else       r_memExc <= w_misaligned;
  end

  assign MemExcW = r_memExc;
`else
  assign MemExcW = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
// ---------------------------------------------------------------------------
// | Module   : tb_mem_stage_unit                                            |
// | Purpose  : Directed vector bench for mem_stage_unit. Each record is     |
// |            one M-stage instruction and the W outputs expected after     |
// |            its clock edge.                                              |
// | Options  : MEM_MISALIGN_TRAP_EN selects the trap expectations.          |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage_unit;

  localparam int OP_NONE = 0, OP_SW = 1, OP_SH = 2, OP_SB = 3, OP_LW = 4,
                 OP_LH = 5, OP_LHU = 6, OP_LB = 7, OP_LBU = 8,
                 OP_JAL = 9, OP_JALR = 10, OP_BGEZALR = 11;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUresultM, MemWriteDataM, PCplus4M;
  logic        jalM, jalrM, bgezalrM, swM, shM, sbM, lwM, lhM, lhuM, lbM, lbuM;
  logic        RegWriteW, MemtoRegW;
  logic [4:0]  WriteRegW;
  logic [31:0] ALUresultW, ReadDataW, PCplus4W;
  logic        jalW, jalrW, bgezalrW, MemExcW;

  always #5 clk = ~clk;

  mem_stage_unit dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WriteRegM(WriteRegM), .ALUresultM(ALUresultM), .MemWriteDataM(MemWriteDataM),
    .PCplus4M(PCplus4M), .jalM(jalM), .jalrM(jalrM), .bgezalrM(bgezalrM),
    .swM(swM), .shM(shM), .sbM(sbM), .lwM(lwM), .lhM(lhM), .lhuM(lhuM),
    .lbM(lbM), .lbuM(lbuM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
    .ALUresultW(ALUresultW), .ReadDataW(ReadDataW), .PCplus4W(PCplus4W),
    .jalW(jalW), .jalrW(jalrW), .bgezalrW(bgezalrW), .MemExcW(MemExcW)
  );

  typedef struct {
    logic        rst;
    int          op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic [31:0] expRd;
    logic        expRw;
    logic        expExc;
  } vec_t;

  vec_t vecs[$];
  int   nApplied = 0;
  int   nFail    = 0;

  function automatic bit isLoad(input int op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

  function automatic bit isStore(input int op);
    return (op >= OP_SW) && (op <= OP_SB);
  endfunction

  task automatic addV(input logic rst, input int op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] pc,
                      input logic [4:0] wreg, input logic [31:0] expRd,
                      input logic expRw, input logic expExc);
    vec_t v;
    v.rst = rst; v.op = op; v.addr = addr; v.wdata = wdata; v.pc = pc;
    v.wreg = wreg; v.expRd = expRd; v.expRw = expRw; v.expExc = expExc;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    RegWriteM     = isLoad(v.op) || (v.op >= OP_JAL);
    MemtoRegM     = isLoad(v.op);
    MemWriteM     = isStore(v.op);
    WriteRegM     = v.wreg;
    ALUresultM    = v.addr;
    MemWriteDataM = v.wdata;
    PCplus4M      = v.pc;
    jalM          = (v.op == OP_JAL);
    jalrM         = (v.op == OP_JALR);
    bgezalrM      = (v.op == OP_BGEZALR);
    swM  = (v.op == OP_SW);  shM  = (v.op == OP_SH);  sbM  = (v.op == OP_SB);
    lwM  = (v.op == OP_LW);  lhM  = (v.op == OP_LH);  lhuM = (v.op == OP_LHU);
    lbM  = (v.op == OP_LB);  lbuM = (v.op == OP_LBU);
  endtask

  // Applies one record for one cycle and compares every W output.
  task automatic runVec(input vec_t v, input string name);
    logic [139:0] act, exp;
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    act = {RegWriteW, MemtoRegW, WriteRegW, ALUresultW, ReadDataW, PCplus4W,
           jalW, jalrW, bgezalrW, MemExcW};
    if (v.rst) exp = '0;
    else exp = {v.expRw, isLoad(v.op) ? 1'b1 : 1'b0, v.wreg, v.addr, v.expRd, v.pc,
                v.op == OP_JAL, v.op == OP_JALR, v.op == OP_BGEZALR, v.expExc};
    nApplied++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got rw=%b m2r=%b wr=%0d alu=%h rd=%h pc=%h j=%b%b%b exc=%b, want rw=%b m2r=%b wr=%0d alu=%h rd=%h pc=%h j=%b%b%b exc=%b",
               name, act[139], act[138], act[137:133], act[132:101], act[100:69],
               act[68:37], act[36], act[35], act[34], act[33],
               exp[139], exp[138], exp[137:133], exp[132:101], exp[100:69],
               exp[68:37], exp[36], exp[35], exp[34], exp[33]);
    end
  endtask

  initial begin
    vec_t v;
    //   rst op          addr          wdata         pc          wr  expRd         rw exc
    addV(1, OP_NONE,    32'h0,        32'h0,        32'h0,      0,  32'h0,        0, 0);
    addV(0, OP_SW,      32'h10,       32'h11223344, 32'h1004,   0,  32'h0,        0, 0);
    addV(0, OP_LW,      32'h10,       32'h0,        32'h1008,   2,  32'h11223344, 1, 0);
    addV(0, OP_SB,      32'h11,       32'h000000AA, 32'h100C,   0,  32'h11223344, 0, 0);
    addV(0, OP_LW,      32'h10,       32'h0,        32'h1010,   3,  32'h1122AA44, 1, 0);
    addV(0, OP_LB,      32'h11,       32'h0,        32'h1014,   4,  32'hFFFFFFAA, 1, 0);
    addV(0, OP_LBU,     32'h11,       32'h0,        32'h1018,   5,  32'h000000AA, 1, 0);
    addV(0, OP_SH,      32'h12,       32'h00008001, 32'h101C,   0,  32'h1122AA44, 0, 0);
    addV(0, OP_LH,      32'h12,       32'h0,        32'h1020,   6,  32'hFFFF8001, 1, 0);
    addV(0, OP_LHU,     32'h12,       32'h0,        32'h1024,   7,  32'h00008001, 1, 0);
    addV(0, OP_LW,      32'h10,       32'h0,        32'h1028,   8,  32'h8001AA44, 1, 0);
    addV(0, OP_LB,      32'h13,       32'h0,        32'h102C,   9,  32'hFFFFFF80, 1, 0);
    addV(0, OP_LBU,     32'h10,       32'h0,        32'h1030,  10,  32'h00000044, 1, 0);
    addV(0, OP_LH,      32'h10,       32'h0,        32'h1034,  11,  32'hFFFFAA44, 1, 0);
    addV(1, OP_SW,      32'h10,       32'hDEADBEEF, 32'h1038,   0,  32'h0,        0, 0);
    addV(0, OP_LW,      32'h10,       32'h0,        32'h103C,  12,  32'h0,        1, 0);
    addV(0, OP_JAL,     32'h0,        32'h0,        32'h3008,  31,  32'h0,        1, 0);
    addV(0, OP_JALR,    32'h0,        32'h0,        32'h300C,  30,  32'h0,        1, 0);
    addV(0, OP_BGEZALR, 32'h0,        32'h0,        32'h3010,  29,  32'h0,        1, 0);
    addV(0, OP_SW,      32'h0,        32'hCAFEF00D, 32'h3014,   0,  32'h0,        0, 0);
    addV(0, OP_LW,      32'h00100000, 32'h0,        32'h3018,  13,  32'h0,        1, 0);
    addV(0, OP_LW,      32'h0,        32'h0,        32'h301C,  14,  32'hCAFEF00D, 1, 0);
    addV(0, OP_SW,      32'h00100004, 32'h55555555, 32'h3020,   0,  32'h0,        0, 0);
    addV(0, OP_LW,      32'h4,        32'h0,        32'h3024,  15,  32'h0,        1, 0);
    addV(0, OP_SW,      32'h3FFC,     32'hA5A5A5A5, 32'h3028,   0,  32'h0,        0, 0);
    addV(0, OP_LW,      32'h3FFC,     32'h0,        32'h302C,  16,  32'hA5A5A5A5, 1, 0);
    addV(0, OP_LW,      32'h4000,     32'h0,        32'h3030,  17,  32'h0,        1, 0);
    // Misaligned word store then reads of the same word.
    addV(0, OP_SW,      32'h13,       32'h12345678, 32'h3034,   0,  32'h0,        0, TRAP);
    addV(0, OP_LW,      32'h10,       32'h0,        32'h3038,  18,
         TRAP ? 32'h0 : 32'h12345678, 1, 0);
    addV(0, OP_LH,      32'h13,       32'h0,        32'h303C,  19,
         TRAP ? 32'h0 : 32'h00001234, !TRAP, TRAP);
    addV(0, OP_NONE,    32'h0,        32'h0,        32'h0,      0,  32'hCAFEF00D, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-sequence reset wipes words written earlier (0x0 and 0x3FFC).
    v.rst = 1; v.op = OP_NONE; v.addr = 0; v.wdata = 0; v.pc = 0; v.wreg = 0;
    v.expRd = 0; v.expRw = 0; v.expExc = 0;
    runVec(v, "midReset");
    v.rst = 0; v.op = OP_LW; v.addr = 32'h3FFC; v.pc = 32'h4000; v.wreg = 20;
    v.expRd = 32'h0; v.expRw = 1;
    runVec(v, "topWordCleared");
    v.addr = 32'h0; v.wreg = 21;
    runVec(v, "word0Cleared");

    // Back-to-back halfword stores into both halves, then a word read.
    v.op = OP_SH; v.addr = 32'h20; v.wdata = 32'hFFFF1357; v.wreg = 0;
    v.expRd = 32'h0; v.expRw = 0;
    runVec(v, "shLo");
    v.addr = 32'h22; v.wdata = 32'h0000BEEF; v.expRd = 32'h00001357;
    runVec(v, "shHi");
    v.op = OP_LW; v.addr = 32'h20; v.wdata = 0; v.wreg = 22;
    v.expRd = 32'hBEEF1357; v.expRw = 1;
    runVec(v, "halvesMerged");

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule

`default_nettype wire
